// File: rtl/dac7311_ctrl_if.sv
// dac7311_ctrl_if: sample handshake plus DAC serial lines between a sample source and dac7311_ctrl
interface dac7311_ctrl_if;
  logic        dac_valid;
  logic [11:0] dac_data;
  logic [1:0]  dac_pd;
  logic        dac_ready;
  logic        dac_done;
  logic        dac_sclk;
  logic        dac_sync_n;
  logic        dac_din;
  modport master (output dac_valid, dac_data, dac_pd,
                  input  dac_ready, dac_done, dac_sclk, dac_sync_n, dac_din);
  modport slave  (input  dac_valid, dac_data, dac_pd,
                  output dac_ready, dac_done, dac_sclk, dac_sync_n, dac_din);
endinterface

// File: rtl/dac7311_ctrl.sv
// dac7311_ctrl: DAC7311 16-bit frame serialiser; define DAC7311_SIGNED_IN_EN for two's-complement input
module dac7311_ctrl #(
  parameter int CLK_STEP = 2
) (
  input logic           clk,
  input logic           rst_n,
  dac7311_ctrl_if.slave dac_io
);
  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;
  localparam logic [7:0] PH_LAST = 8'(CLK_STEP - 1);
  state_t      state_q, state_d;
  logic [7:0]  ph_q, ph_d;
  logic [3:0]  bit_q, bit_d;
  logic [15:0] sh_q, sh_d;
  logic        sync_n_q, sync_n_d;
  logic        sclk_q, sclk_d;
  logic        din_q, din_d;
  logic        ready_q, ready_d;
  logic        done_q, done_d;
  logic [11:0] code;
  logic        accept;
`ifdef DAC7311_SIGNED_IN_EN
  assign code = {~dac_io.dac_data[11], dac_io.dac_data[10:0]};
`else
  assign code = dac_io.dac_data;
`endif
  assign accept = dac_io.dac_valid && ready_q;
  // Next state: bit_q indexes the bit being clocked and is reused as the half counter in HOLD
  always_comb begin
    state_d  = state_q;
    ph_d     = ph_q;
    bit_d    = bit_q;
    sh_d     = sh_q;
    sync_n_d = sync_n_q;
    sclk_d   = sclk_q;
    din_d    = din_q;
    ready_d  = ready_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: if (accept) begin
        state_d  = SETUP;
        sh_d     = {dac_io.dac_pd, code, 2'b00};
        din_d    = dac_io.dac_pd[1];
        sync_n_d = 1'b0;
        ph_d     = PH_LAST;
        bit_d    = 4'd15;
        ready_d  = 1'b0;
      end
      SETUP: if (ph_q != 8'd0) ph_d = ph_q - 8'd1;
      else begin
        state_d = SHIFT;
        sclk_d  = 1'b0;
        ph_d    = PH_LAST;
      end
      SHIFT: if (ph_q != 8'd0) ph_d = ph_q - 8'd1;
      else begin
        ph_d   = PH_LAST;
        sclk_d = ~sclk_q;
        if (!sclk_q) begin
          if (bit_q != 4'd0) begin
            din_d = sh_q[14];
            sh_d  = {sh_q[14:0], 1'b0};
          end
        end else if (bit_q == 4'd0) begin
          state_d  = HOLD;
          sync_n_d = 1'b1;
          sclk_d   = 1'b1;
          din_d    = 1'b0;
          bit_d    = 4'd1;
        end else bit_d = bit_q - 4'd1;
      end
      HOLD: if (ph_q != 8'd0) ph_d = ph_q - 8'd1;
      else if (bit_q != 4'd0) begin
        bit_d = 4'd0;
        ph_d  = PH_LAST;
      end else begin
        state_d = IDLE;
        ready_d = 1'b1;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  // State and registered outputs; reset drops any partial frame immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ph_q     <= '0;
      bit_q    <= '0;
      sh_q     <= '0;
      sync_n_q <= 1'b1;
      sclk_q   <= 1'b1;
      din_q    <= 1'b0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ph_q     <= ph_d;
      bit_q    <= bit_d;
      sh_q     <= sh_d;
      sync_n_q <= sync_n_d;
      sclk_q   <= sclk_d;
      din_q    <= din_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
    end
  end
  assign dac_io.dac_sync_n = sync_n_q;
  assign dac_io.dac_sclk   = sclk_q;
  assign dac_io.dac_din    = din_q;
  assign dac_io.dac_ready  = ready_q;
  assign dac_io.dac_done   = done_q;
endmodule

// File: tb/tb_dac7311_ctrl.sv
// tb_dac7311_ctrl: directed frame vectors plus back-to-back, busy-ignore and mid-frame reset sequences
module tb_dac7311_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  dac7311_ctrl_if bus();
  dac7311_ctrl #(.CLK_STEP(2)) dut (.clk(clk), .rst_n(rst_n), .dac_io(bus));
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic [11:0] d;
    logic [1:0]  p;
    logic [15:0] fr;
  } vec_t;
  vec_t vecs[6];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic check_idle(input string name);
    check({name, "_sync_n"}, bus.dac_sync_n, 1);
    check({name, "_sclk"}, bus.dac_sclk, 1);
    check({name, "_din"}, bus.dac_din, 0);
    check({name, "_ready"}, bus.dac_ready, 1);
    check({name, "_done"}, bus.dac_done, 0);
  endtask
  task automatic frame_run(input logic [11:0] d, input logic [1:0] p, input bit skip_start,
                           input int inj, input bit b2b, input logic [11:0] d2, input logic [1:0] p2,
                           output logic [15:0] fr, output int fall_at, output int rise_at,
                           output int low_n, output int done_at, output int nfall, output int rdy_busy);
    int w;
    bit ps, pc;
    fr = '0; fall_at = -1; rise_at = -1; low_n = 0; done_at = -1; nfall = 0; rdy_busy = 0;
    if (!skip_start) begin
      w = 0;
      while (!bus.dac_ready && w < 100) begin
        @(negedge clk);
        w++;
      end
      check("ready_before_start", bus.dac_ready, 1);
      bus.dac_valid = 1'b1;
      bus.dac_data = d;
      bus.dac_pd = p;
    end
    @(posedge clk);
    @(negedge clk);
    if (b2b) begin
      bus.dac_data = d2;
      bus.dac_pd = p2;
    end else bus.dac_valid = 1'b0;
    ps = 1'b1;
    pc = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      if (k > 1) @(negedge clk);
      if (k == inj) begin
        bus.dac_valid = 1'b1;
        bus.dac_data = ~d;
        bus.dac_pd = ~p;
      end else if (k == inj + 1) bus.dac_valid = 1'b0;
      if (!bus.dac_sync_n) begin
        low_n++;
        if (fall_at < 0) fall_at = k;
        if (pc && !bus.dac_sclk) begin
          fr = {fr[14:0], bus.dac_din};
          nfall++;
        end
      end
      if (bus.dac_sync_n && !ps && rise_at < 0) rise_at = k;
      if (bus.dac_ready && !bus.dac_done) rdy_busy++;
      ps = bus.dac_sync_n;
      pc = bus.dac_sclk;
      if (bus.dac_done) begin
        done_at = k;
        break;
      end
    end
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not reach its end");
    $fatal(1);
  end
  initial begin
    logic [15:0] fr, fr2;
    int fa, ra, ln, da, nf, rb, fa2, ra2, ln2, da2, nf2, rb2, cnt;
`ifdef DAC7311_SIGNED_IN_EN
    vecs[0] = '{12'hA5C, 2'b00, 16'h0970};
    vecs[1] = '{12'h800, 2'b00, 16'h0000};
    vecs[2] = '{12'h7FF, 2'b00, 16'h3FFC};
    vecs[3] = '{12'h000, 2'b11, 16'hE000};
    vecs[4] = '{12'hFFF, 2'b00, 16'h1FFC};
    vecs[5] = '{12'h123, 2'b01, 16'h648C};
`else
    vecs[0] = '{12'hA5C, 2'b00, 16'h2970};
    vecs[1] = '{12'h800, 2'b00, 16'h2000};
    vecs[2] = '{12'h7FF, 2'b00, 16'h1FFC};
    vecs[3] = '{12'h000, 2'b11, 16'hC000};
    vecs[4] = '{12'hFFF, 2'b00, 16'h3FFC};
    vecs[5] = '{12'h123, 2'b01, 16'h448C};
`endif
    bus.dac_valid = 1'b0;
    bus.dac_data = '0;
    bus.dac_pd = '0;
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    check_idle("in_reset");
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check_idle($sformatf("post_reset%0d", c));
    end
    for (int i = 0; i < 6; i++) begin
      frame_run(vecs[i].d, vecs[i].p, 0, -1, 0, '0, '0, fr, fa, ra, ln, da, nf, rb);
      check($sformatf("v%0d_frame", i), fr, vecs[i].fr);
      check($sformatf("v%0d_sync_fall", i), fa, 1);
      check($sformatf("v%0d_sync_low", i), ln, 66);
      check($sformatf("v%0d_sync_rise", i), ra, 67);
      check($sformatf("v%0d_done_at", i), da, 71);
      check($sformatf("v%0d_falls", i), nf, 16);
      check($sformatf("v%0d_ready_busy", i), rb, 0);
    end
    frame_run(12'h000, 2'b11, 0, 20, 0, '0, '0, fr, fa, ra, ln, da, nf, rb);
    check("busy_frame", fr, vecs[3].fr);
    check("busy_done_at", da, 71);
    check("busy_sync_low", ln, 66);
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (!bus.dac_sync_n || !bus.dac_sclk || bus.dac_done || !bus.dac_ready) cnt++;
    end
    check("busy_no_second_frame", cnt, 0);
    frame_run(12'h123, 2'b01, 0, -1, 1, 12'hA5C, 2'b00, fr, fa, ra, ln, da, nf, rb);
    frame_run(12'h000, 2'b00, 1, -1, 0, '0, '0, fr2, fa2, ra2, ln2, da2, nf2, rb2);
    check("b2b_frame1", fr, vecs[5].fr);
    check("b2b_rise1", ra, 67);
    check("b2b_done1", da, 71);
    check("b2b_fall2", fa2, 1);
    check("b2b_sync_high", da - ra + fa2, 5);
    check("b2b_frame2", fr2, vecs[0].fr);
    check("b2b_low2", ln2, 66);
    check("b2b_done2", da2, 71);
    @(negedge clk);
    bus.dac_valid = 1'b1;
    bus.dac_data = 12'h5A5;
    bus.dac_pd = 2'b00;
    @(posedge clk);
    @(negedge clk);
    bus.dac_valid = 1'b0;
    repeat (29) @(negedge clk);
    check("rst_mid_sync_low", bus.dac_sync_n, 0);
    rst_n = 1'b0;
    #1;
    check_idle("rst_mid_async");
    cnt = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (bus.dac_done || !bus.dac_sync_n) cnt++;
    end
    check("rst_mid_no_done", cnt, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("rst_mid_release");
    frame_run(12'hFFF, 2'b00, 0, -1, 0, '0, '0, fr, fa, ra, ln, da, nf, rb);
    check("after_rst_frame", fr, vecs[4].fr);
    check("after_rst_falls", nf, 16);
    check("after_rst_sync_low", ln, 66);
    check("after_rst_done", da, 71);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
